// File: rtl/mac_acc_drain.sv
`default_nettype none
// ============================================================================
// Module   : mac_acc_drain
// Snapshots four accumulator lanes and streams enabled words over valid/ready.
// Option   : define MAC_DRAIN_LAST_EN to add the dout_last_o port.
// Revision : 1.0  initial release
// ============================================================================
module mac_acc_drain #(
    parameter int MAC_MIN_WIDTH = 8,
    parameter int MAC_ACC_WIDTH = 4*MAC_MIN_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               cfg_mode_i,
    input  logic [3:0]               res_mask_i,
    input  logic [MAC_ACC_WIDTH-1:0] in0_i,
    input  logic [MAC_ACC_WIDTH-1:0] in1_i,
    input  logic [MAC_ACC_WIDTH-1:0] in2_i,
    input  logic [MAC_ACC_WIDTH-1:0] in3_i,
    input  logic                     cap_valid_i,
    output logic                     cap_ready_o,
    output logic [MAC_ACC_WIDTH-1:0] dout_o,
    output logic [1:0]               dout_idx_o,
    output logic                     dout_valid_o,
    input  logic                     dout_ready_i,
`ifdef MAC_DRAIN_LAST_EN
    output logic                     dout_last_o,
`endif
    output logic                     done_o
);

    // Lane-grouping encodings shared with the accumulator block
    localparam logic [1:0] c_MAC_SINGLE = 2'd0;
    localparam logic [1:0] c_MAC_DUAL   = 2'd1;
    localparam logic [1:0] c_MAC_QUAD   = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                   state_q;
    logic [MAC_ACC_WIDTH-1:0] snap_q [4];
    logic [3:0]               wen_q;
    logic [MAC_ACC_WIDTH-1:0] dout_q;
    logic [1:0]               idx_q;
    logic                     valid_q;
    logic                     done_q;

    logic [MAC_ACC_WIDTH-1:0] w_in [4];
    logic [3:0]               w_cap_wen;
    logic                     w_cap_fire;
    logic                     w_beat;
    logic [2:0]               w_first_scan;
    logic [2:0]               w_next_scan;

    // {found, index} of the lowest set bit of en at or above position lo
    function automatic logic [2:0] f_scan(input logic [3:0] en, input int lo);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (en[i] && (i >= lo)) begin
                r = {1'b1, 2'(i)};
            end
        end
        return r;
    endfunction

    assign w_in[0] = in0_i;
    assign w_in[1] = in1_i;
    assign w_in[2] = in2_i;
    assign w_in[3] = in3_i;

    always_comb begin
        w_cap_wen = res_mask_i;
        case (cfg_mode_i)
            c_MAC_SINGLE: w_cap_wen = res_mask_i;
            c_MAC_DUAL:   w_cap_wen = {{2{res_mask_i[1]}}, {2{res_mask_i[0]}}};
            c_MAC_QUAD:   w_cap_wen = {4{res_mask_i[0]}};
            default:      w_cap_wen = res_mask_i;
        endcase
    end

    assign cap_ready_o  = (state_q == S_IDLE);
    assign w_cap_fire   = cap_valid_i & cap_ready_o;
    assign w_beat       = valid_q & dout_ready_i;
    assign w_first_scan = f_scan(w_cap_wen, 0);
    assign w_next_scan  = f_scan(wen_q, int'(idx_q) + 1);

`ifdef MAC_DRAIN_LAST_EN
    logic       last_q;
    logic [2:0] w_first_rest;
    logic [2:0] w_next_rest;

    // A word is last when nothing enabled lies above it
    assign w_first_rest = f_scan(w_cap_wen, int'(w_first_scan[1:0]) + 1);
    assign w_next_rest  = f_scan(wen_q, int'(w_next_scan[1:0]) + 1);
    assign dout_last_o  = last_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            for (int i = 0; i < 4; i++) begin
                snap_q[i] <= '0;
            end
            wen_q   <= 4'b0000;
            dout_q  <= '0;
            idx_q   <= 2'd0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef MAC_DRAIN_LAST_EN
            last_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_cap_fire) begin
                        for (int i = 0; i < 4; i++) begin
                            snap_q[i] <= w_in[i];
                        end
                        wen_q <= w_cap_wen;
                        // First word comes straight from the inputs to hit latency 1
                        if (w_first_scan[2]) begin
                            state_q <= S_SEND;
                            idx_q   <= w_first_scan[1:0];
                            dout_q  <= w_in[w_first_scan[1:0]];
                            valid_q <= 1'b1;
`ifdef MAC_DRAIN_LAST_EN
                            last_q  <= ~w_first_rest[2];
`endif
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                S_SEND: begin
                    if (w_beat) begin
                        if (w_next_scan[2]) begin
                            idx_q  <= w_next_scan[1:0];
                            dout_q <= snap_q[w_next_scan[1:0]];
`ifdef MAC_DRAIN_LAST_EN
                            last_q <= ~w_next_rest[2];
`endif
                        end else begin
                            state_q <= S_IDLE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
`ifdef MAC_DRAIN_LAST_EN
                            last_q  <= 1'b0;
`endif
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout_o       = dout_q;
    assign dout_idx_o   = idx_q;
    assign dout_valid_o = valid_q;
    assign done_o       = done_q;

endmodule
`default_nettype wire

// File: doc/mac_acc_drain.md
# mac_acc_drain

Output drain stage directly downstream of the MAC accumulator block. Captures the four MAC_ACC_WIDTH accumulator lanes (out0..out3) as one snapshot, reinterprets them per MAC mode (single/dual/quad lane grouping from mac_const.vh), and streams the enabled results out as MAC_ACC_WIDTH-wide words over a valid/ready interface, low word first. Lets the array hand results to a narrow fabric/readout path without stalling the accumulators longer than one capture cycle.

## Interface
- MAC_MIN_WIDTH, 8, base lane granularity (matches accumulator block)
- MAC_ACC_WIDTH, 4*MAC_MIN_WIDTH, width of each lane and of each output word
- clk  input  1  clock; all state updates on posedge clk
- rst  input  1  synchronous, active-high reset
- cfg_mode  input  2  lane grouping, `MAC_SINGLE` / `MAC_DUAL` / `MAC_QUAD`; sampled only at capture
- res_mask  input  4  result enable, sampled at capture; single: bit i = lane i; dual: bit k = lanes 2k,2k+1; quad: bit 0 = all lanes; unused bits ignored
- in0..in3  input  MAC_ACC_WIDTH each  accumulator lane values, sampled at capture
- cap_valid  input  1  request to capture snapshot
- cap_ready  output  1  high only in IDLE
- dout  output  MAC_ACC_WIDTH  current word
- dout_idx  output  2  lane index of current word (0..3)
- dout_valid  output  1  dout/dout_idx valid
- dout_ready  input  1  consumer accepts word
- done  output  1  one-cycle pulse after snapshot fully drained

## Operation
- FSM states: IDLE, SEND.
- Capture: cap_valid & cap_ready in IDLE. Store in0..in3 in a 4-word snapshot register; compute 4-bit word-enable vector wen: single wen=res_mask; dual wen={m1,m1,m0,m0}; quad wen={4{m0}}. Any non-defined cfg_mode encoding is treated as single.
- If wen==0: stay IDLE, assert done next cycle, no beats.
- Else: go SEND, word pointer = lowest set bit of wen.
- SEND: dout=snapshot[ptr], dout_idx=ptr, dout_valid=1. On dout_valid & dout_ready: if no higher set bit in wen, go IDLE and pulse done next cycle; else ptr = next higher set bit (skip disabled words, no wrap).
- Dual/quad results are emitted as consecutive words low lane first; no arithmetic, no carry, bit-exact copy of lanes.
- in0..in3, cfg_mode, res_mask changing during SEND have no effect.
- dout, dout_idx stable while dout_valid & !dout_ready.

## Timing
- Reset: state IDLE, cap_ready=1 (first cycle after rst deasserts), dout_valid=0, dout=0, dout_idx=0, done=0, snapshot and wen cleared.
- rst during SEND: aborts drain; snapshot discarded; no done pulse.
- Capture at edge t -> first word valid in cycle t+1 (latency 1).
- One word per cycle at full throughput (dout_ready held high); N enabled words take N cycles in SEND.
- Final word accepted at edge t -> IDLE and done=1 in cycle t+1; cap_ready=1 in same cycle; new capture possible at edge t+1 (one bubble between snapshots).
- cap_ready is registered state-decode, no combinational path from dout_ready.
- done never coincides with dout_valid=1.

## Configuration
- `MAC_DRAIN_LAST_EN` defined: extra output port dout_last (1 bit), high with dout_valid on the final word of a snapshot, 0 otherwise and at reset.
- Not defined: no dout_last port; all other behaviour identical.

## Test plan
- Single mode, res_mask=4'b1111, in0..in3=0x11111111,0x22222222,0x33333333,0x44444444, dout_ready=1 -> 4 consecutive words in that order, dout_idx 0,1,2,3, done pulse 1 cycle after 4th word, cap_ready back high same cycle.
- Dual mode, res_mask=4'b0010, in2=0xDEADBEEF, in3=0x00000001 -> exactly two words 0xDEADBEEF (idx 2) then 0x00000001 (idx 3); lanes 0,1 never emitted.
- Quad mode, res_mask=4'b0001, dout_ready toggling 1,0,0,1,... -> 4 words idx 0..3, each held unchanged through stall cycles; res_mask=4'b1110 in quad -> no words, done pulse next cycle.
- Change in0..in3 and cfg_mode every cycle during SEND -> emitted words equal captured snapshot; cap_valid held high during SEND -> no second capture until IDLE.
- Assert rst after 2nd word of a 4-word single drain -> next cycle dout_valid=0, done=0, dout=0; after release, new capture drains normally.
- With `MAC_DRAIN_LAST_EN`: single mode res_mask=4'b0101 -> words idx 0 then 2, dout_last=0 then 1.
